// File: rtl/pulse_cmd_pkg.sv
// Shared definitions for the pulse generator UART command link:
// opcode values, frame geometry and FSM state encodings.
package pulse_cmd_pkg;

   localparam logic [7:0] CONT_SET_DELAY     = 8'd0;
   localparam logic [7:0] CONT_SET_PERIOD    = 8'd1;
   localparam logic [7:0] CONT_SET_PULSE1    = 8'd2;
   localparam logic [7:0] CONT_SET_PULSE2    = 8'd3;
   localparam logic [7:0] CONT_TOGGLE_PULSE1 = 8'd4;
   localparam logic [7:0] CONT_SET_CPMG      = 8'd5;
   localparam logic [7:0] CONT_SET_ATT       = 8'd6;
   localparam logic [7:0] CONT_SET_NUTW      = 8'd7;
   localparam logic [7:0] CONT_SET_NUTD      = 8'd8;

   localparam int unsigned CMD_FRAME_BYTES = 5;

   // Byte serializer states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Frame sequencer states
   localparam logic [0:0] FRM_IDLE = 1'b0;
   localparam logic [0:0] FRM_SEND = 1'b1;

   function automatic logic opcode_legal(input logic [7:0] op, input int unsigned max_op);
      return 32'(op) <= max_op;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART serializer with a valid/ready byte handshake.
// ready rises in the last stop-bit cycle so consecutive bytes run gap-free.
module uart_tx_byte #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic [7:0] byte_data,
   output logic       tx
);
   import pulse_cmd_pkg::*;

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             bit_end;
   logic             load;

   assign bit_end    = (bit_cnt == CNT_LAST);
   assign byte_ready = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);
   assign load       = byte_valid && byte_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else if (load) begin
         state   <= ST_START;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= byte_data;
         tx      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               bit_cnt <= '0;
               tx      <= 1'b1;
            end
            ST_START: begin
               if (bit_end) begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                  tx      <= shreg[0];
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                     tx    <= 1'b1;
                  end else begin
                     // shreg[0] is the bit on the line, so the next one is shreg[1]
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx      <= shreg[1];
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  state   <= ST_IDLE;
                  bit_cnt <= '0;
                  tx      <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/cmd_uart_tx.sv
// Host-side command serializer: one opcode + 32-bit payload per handshake,
// sent as five back-to-back 8N1 bytes (opcode, then payload LSB-first).
module cmd_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned MAX_OPCODE   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_opcode,
   input  logic [31:0] cmd_data,
   output logic        tx,
   output logic        busy,
   output logic        frame_done,
   output logic        cmd_err
);
   import pulse_cmd_pkg::*;

   logic [0:0]  frame_state;
   logic [2:0]  byte_idx;
   logic [31:0] data_q;
   logic        byte_valid;
   logic        byte_ready;
   logic [7:0]  byte_data;
   logic        legal;
   logic        last_byte;

   assign cmd_ready = (frame_state == FRM_IDLE);
   assign busy      = (frame_state == FRM_SEND);
   assign legal     = opcode_legal(cmd_opcode, MAX_OPCODE);
   assign last_byte = (byte_idx == 3'(CMD_FRAME_BYTES - 1));

   // The opcode goes straight into the serializer on the accept edge so the
   // start bit appears in the following cycle; only the payload is held here.
   always_comb begin
      byte_valid = 1'b0;
      byte_data  = cmd_opcode;
      if (frame_state == FRM_IDLE) begin
         byte_valid = cmd_valid && legal;
      end else if (byte_ready && !last_byte) begin
         byte_valid = 1'b1;
         case (byte_idx)
            3'd0:    byte_data = data_q[7:0];
            3'd1:    byte_data = data_q[15:8];
            3'd2:    byte_data = data_q[23:16];
            default: byte_data = data_q[31:24];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_state <= FRM_IDLE;
         byte_idx    <= '0;
         data_q      <= '0;
         frame_done  <= 1'b0;
         cmd_err     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         cmd_err    <= 1'b0;
         if (frame_state == FRM_IDLE) begin
            if (cmd_valid) begin
               if (legal) begin
                  frame_state <= FRM_SEND;
                  byte_idx    <= '0;
                  data_q      <= cmd_data;
               end else begin
                  cmd_err <= 1'b1;
               end
            end
         end else if (byte_ready) begin
            if (last_byte) begin
               frame_state <= FRM_IDLE;
               byte_idx    <= '0;
               frame_done  <= 1'b1;
            end else begin
               byte_idx <= byte_idx + 3'd1;
            end
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk       (clk),
      .reset     (reset),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .byte_data (byte_data),
      .tx        (tx)
   );

endmodule

// File: doc/cmd_uart_tx.md
Name: cmd_uart_tx

Overview:
Host-side command serializer for the pulse generator's UART control port; it is the transmit end of the link that pulse_gen receives on RS232_Rx.
- Accepts one command (8-bit opcode + 32-bit payload) over a valid/ready handshake.
- Emits it as a 5-byte 8N1 UART frame: opcode byte, then payload bytes LSB-first.
- Used in benches as the stimulus driver for pulse_gen, and in the companion host-bridge FPGA build.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 2
MAX_OPCODE, 8, highest legal opcode (CONT_SET_NUTD); larger opcodes are rejected

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block idle and able to accept a command
cmd_opcode  input  8  command opcode (CONT_* value)
cmd_data  input  32  command payload
tx  output  1  UART serial line, idle high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse when the final stop bit completes
cmd_err  output  1  one-cycle pulse when an illegal opcode is rejected

Behaviour:
- Reset values: tx=1, cmd_ready=1, busy=0, frame_done=0, cmd_err=0. State=IDLE; all counters 0.
- Reset has priority over every other event. Reset mid-frame:
  - tx=1 at the next edge.
  - Frame is aborted; no frame_done is generated.
  - cmd_valid is ignored while reset is high.
- Accept: at the edge where cmd_valid & cmd_ready (cycle k), opcode and data are captured. Later input changes are ignored until the next accept.
- cmd_ready = (state==IDLE). It is combinational from state; there is no dependence on cmd_valid.
- Illegal opcode (cmd_opcode > MAX_OPCODE) at accept:
  - Nothing is transmitted; tx stays 1.
  - Cycle k+1: cmd_err=1 for one cycle, cmd_ready=1, busy=0.
- Legal opcode: states are IDLE -> START -> DATA -> STOP.
  - STOP -> START if byte_idx<4 (byte_idx increments); STOP -> IDLE if byte_idx==4.
  - Each state holds for exactly CLKS_PER_BIT cycles. DATA holds for 8 such bit periods.
  - The bit-period counter runs 0..CLKS_PER_BIT-1; its width is clog2(CLKS_PER_BIT).
- Line timing: tx=0 (start bit) from cycle k+1. Data bits are LSB first. Stop bit is 1.
- Bytes are back-to-back with no idle gap between a stop bit and the next start bit.
- Byte order: byte0=opcode, byte1=data[7:0], byte2=data[15:8], byte3=data[23:16], byte4=data[31:24].
- Frame length is 50*CLKS_PER_BIT cycles.
  - busy=1 during cycles k+1 .. k+50*CLKS_PER_BIT.
  - Cycle k+1+50*CLKS_PER_BIT: frame_done=1 (one cycle), cmd_ready=1, busy=0, tx=1.
- Back-to-back commands: if cmd_valid is held high, the next accept happens in the frame_done cycle. The next start bit therefore follows after exactly one idle-high cycle.
- tx is driven from a register, with no combinational path from inputs, so it is glitch-free.

Decomposition:
- Shared package pulse_cmd_pkg holds:
  - Opcode constants CONT_SET_DELAY=0, CONT_SET_PERIOD=1, CONT_SET_PULSE1=2, CONT_SET_PULSE2=3, CONT_TOGGLE_PULSE1=4, CONT_SET_CPMG=5, CONT_SET_ATT=6, CONT_SET_NUTW=7, CONT_SET_NUTD=8.
  - CMD_FRAME_BYTES=5.
  - The FSM state encoding.
- One sub-module, uart_tx_byte: a single-byte 8N1 serializer with its own byte valid/ready handshake and the CLKS_PER_BIT parameter. cmd_uart_tx sequences the 5 bytes through it and owns the frame and error logic.
- uart_tx_byte must meet the back-to-back timing above: ready is asserted in the final stop-bit cycle so the next byte loads with no gap.

Test Plan:
- CLKS_PER_BIT=4. Send CONT_SET_DELAY with data 0x00000064.
  - tx samples at bit centres show bytes 0x00, 0x64, 0x00, 0x00, 0x00, each as start 0, LSB first, stop 1.
  - frame_done occurs exactly 201 cycles after accept; busy is high for 200 cycles.
- Opcode 0x09 with data 0xDEADBEEF: cmd_err pulses one cycle after accept, tx stays 1 for 300 cycles, frame_done never fires.
- cmd_valid held high with two queued commands (CONT_SET_PERIOD 0x12345678, then CONT_SET_ATT 0x0000001F): the second start bit falls exactly one idle cycle after the first frame_done. Decoded bytes are 01 78 56 34 12 and 06 1F 00 00 00.
- Pulse reset during byte2 of a frame: tx=1 on the next edge, cmd_ready=1, no frame_done. A new command after reset is transmitted correctly from its start bit.
- Change cmd_opcode/cmd_data every cycle after accept of CONT_SET_CPMG 0xA5A5A5A5: the transmitted bytes remain 05 A5 A5 A5 A5.
- CLKS_PER_BIT=2 corner: CONT_SET_NUTD 0xFFFFFFFF gives a 100-cycle frame with correct bit widths.
